pairwise_xnor_matrix: RTL and testbench

- Compares five 1-bit inputs (a, b, c, d, e) against each other in every ordered pair and outputs the 25-bit equality matrix.
- Also outputs a count of equal pairs and an all-equal flag.
- Registered block with one-cycle latency, used as a small compare/equality stage in the datapath.

---
 rtl/pairwise_xnor_matrix_pkg.sv | 12 +
 rtl/pairwise_xnor_matrix_if.sv | 26 ++
 rtl/pairwise_xnor_matrix_popcount.sv | 16 +
 rtl/pairwise_xnor_matrix.sv | 67 ++++++
 tb/tb_pairwise_xnor_matrix.sv | 132 +++++++++++++
 5 files changed

// File: rtl/pairwise_xnor_matrix_pkg.sv
// Shared constants for the pairwise XNOR equality matrix stage.
// The package name is fixed by the block's decomposition; the file follows the bundle layout.
package pairwise_xnor_pkg;

    localparam int unsigned N_IN  = 5;
    localparam int unsigned OUT_W = N_IN * N_IN;
    localparam int unsigned CNT_W = 5;

    localparam logic [OUT_W-1:0] ALL_ONES = 25'h1FFFFFF;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUT_W);

endpackage

// File: rtl/pairwise_xnor_matrix_if.sv
// Operand/result bundle for pairwise_xnor_matrix; master drives operands, slave returns results.
interface pairwise_xnor_matrix_if;
    import pairwise_xnor_pkg::*;

    logic             in_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [CNT_W-1:0] match_count;
    logic             all_equal;

    modport master (
        output in_valid, a, b, c, d, e,
        input  out, out_valid, match_count, all_equal
    );

    modport slave (
        input  in_valid, a, b, c, d, e,
        output out, out_valid, match_count, all_equal
    );

endinterface

// File: rtl/pairwise_xnor_matrix_popcount.sv
// Combinational population count of the 25-bit equality matrix.
module popcount25
    import pairwise_xnor_pkg::*;
(
    input  logic [OUT_W-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/pairwise_xnor_matrix.sv
// Registered 5x5 equality matrix of a..e with match count and all-equal flag, one-cycle latency.
module pairwise_xnor_matrix
    import pairwise_xnor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pairwise_xnor_matrix_if.slave bus
);

    logic [N_IN-1:0]  x;
    logic [OUT_W-1:0] mat;
    logic [CNT_W-1:0] mat_cnt;

    logic [OUT_W-1:0] out_d,       out_q;
    logic [CNT_W-1:0] cnt_d,       cnt_q;
    logic             all_eq_d,    all_eq_q;
    logic             out_valid_d, out_valid_q;

    assign x = {bus.e, bus.d, bus.c, bus.b, bus.a};

    // Row i is operand xi compared against x0..x4; row 0 lands in the MSBs.
    always_comb begin
        mat = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            for (int j = 0; j < int'(N_IN); j++) begin
                mat[int'(OUT_W) - 1 - int'(N_IN) * i - j] = ~(x[i] ^ x[j]);
            end
        end
    end

    popcount25 u_popcount (
        .vec_i (mat),
        .cnt_o (mat_cnt)
    );

    always_comb begin
        out_d       = out_q;
        cnt_d       = cnt_q;
        all_eq_d    = all_eq_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            out_d    = mat;
            cnt_d    = mat_cnt;
            all_eq_d = (mat_cnt == MAX_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            cnt_q       <= '0;
            all_eq_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            all_eq_q    <= all_eq_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
    assign bus.all_equal   = all_eq_q;
    assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_pairwise_xnor_matrix.sv
// Self-checking bench: directed literal vectors, then random traffic against a behavioural model.
module tb_pairwise_xnor_matrix;
    import pairwise_xnor_pkg::*;

    logic clk;
    logic rst;

    pairwise_xnor_matrix_if bus ();

    pairwise_xnor_matrix u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // Model state: what the outputs must show after the most recent edge.
    logic [24:0] m_out;
    logic [4:0]  m_cnt;
    logic        m_all;
    logic        m_valid;

    initial begin
        m_out   = '0;
        m_cnt   = '0;
        m_all   = 1'b0;
        m_valid = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // x = {a,b,c,d,e}; matrix = ~{5{a},5{b},5{c},5{d},5{e}} ^ {5{a,b,c,d,e}}.
    function automatic logic [24:0] model_mat(input logic [4:0] x);
        logic [24:0] rows;
        rows = {{5{x[4]}}, {5{x[3]}}, {5{x[2]}}, {5{x[1]}}, {5{x[0]}}};
        return ~rows ^ {5{x}};
    endfunction

    // Equal ordered pairs: ones pair with ones, zeros with zeros.
    function automatic logic [4:0] model_cnt(input logic [4:0] x);
        int n1;
        n1 = $countones(x);
        return 5'(n1 * n1 + (5 - n1) * (5 - n1));
    endfunction

    task automatic step(input logic r, input logic v, input logic [4:0] x);
        rst          = r;
        bus.in_valid = v;
        {bus.a, bus.b, bus.c, bus.d, bus.e} = x;
        @(posedge clk);
        if (r) begin
            m_out = '0; m_cnt = '0; m_all = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                m_out = model_mat(x);
                m_cnt = model_cnt(x);
                m_all = (x == 5'b00000) || (x == 5'b11111);
            end
        end
        cmp_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out_valid",   32'(bus.out_valid),   32'(m_valid));
            check("model_out",         32'(bus.out),         32'(m_out));
            check("model_match_count", 32'(bus.match_count), 32'(m_cnt));
            check("model_all_equal",   32'(bus.all_equal),   32'(m_all));
        end
    end

    task automatic lit(input string name, input logic [24:0] o, input logic [4:0] c,
                       input logic ae, input logic ov);
        @(negedge clk);
        #1;
        check({name, "_out"},   32'(bus.out),         32'(o));
        check({name, "_cnt"},   32'(bus.match_count), 32'(c));
        check({name, "_all"},   32'(bus.all_equal),   32'(ae));
        check({name, "_valid"}, 32'(bus.out_valid),   32'(ov));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        {bus.a, bus.b, bus.c, bus.d, bus.e} = 5'b0;

        step(1'b1, 1'b1, 5'b11111);
        lit("reset1", 25'h0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'b11111);
        lit("reset2", 25'h0, 5'd0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 5'b00000);
        lit("zeros", 25'h1FFFFFF, 5'd25, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'b10101);
        lit("alt10101", 25'h1555555, 5'd13, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'b11111);
        lit("ones", 25'h1FFFFFF, 5'd25, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'b01010);
        lit("alt01010", 25'h1555555, 5'd13, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'b11100);
        lit("hold", 25'h1555555, 5'd13, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'b11000);
        lit("rst_prio", 25'h0, 5'd0, 1'b0, 1'b0);

        // Single-mismatch vector: a differs from b..e, 4*4 + 1*1 = 17 equal pairs.
        step(1'b0, 1'b1, 5'b10000);
        lit("one_off", 25'b10000_01111_01111_01111_01111, 5'd17, 1'b0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
